// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encoding, and the request legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam int WORD_OFS = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RDW,
      S_WR,
      S_RESP
   } state_t;

   // Misaligned half/word or an unused funct3 encoding; such requests never touch memory.
   function automatic logic req_err(input logic [2:0] f3, input logic [1:0] ofs);
      case (f3)
         F3_B, F3_BU: return 1'b0;
         F3_H, F3_HU: return ofs[0];
         F3_W:        return |ofs;
         default:     return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering shared by loads (extract + sign/zero extend) and sub-word stores (merge into old word).
// Purely combinational; the caller guarantees the offset is aligned for the access size.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  ofs,
   input  logic [31:0] mem_word,
   input  logic [31:0] st_data,
   output logic [31:0] ld_data,
   output logic [31:0] st_merged
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = mem_word[{ofs, 3'b000} +: 8];
      lane_h = mem_word[{ofs[1], 4'b0000} +: 16];

      case (funct3)
         F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
         F3_BU:   ld_data = {24'd0, lane_b};
         F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
         F3_HU:   ld_data = {16'd0, lane_h};
         default: ld_data = mem_word;
      endcase

      // Only the addressed lane is replaced; untouched bytes keep what the RAM returned.
      st_merged = mem_word;
      case (funct3)
         F3_B, F3_BU: st_merged[{ofs, 3'b000} +: 8]     = st_data[7:0];
         F3_H, F3_HU: st_merged[{ofs[1], 4'b0000} +: 16] = st_data[15:0];
         default:     st_merged = st_data;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// One-at-a-time RV32I load/store initiator on a word-only RAM port; sub-word stores use read-modify-write.
// Latency accept->resp: load 3, SW 2, SB/SH 4, error 1; req_ready only in IDLE, resp has no backpressure.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            f3_q, f3_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
   logic                  mem_we_q, mem_we_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q, resp_err_d;

   logic [DATA_WIDTH-1:0] ld_data;
   logic [DATA_WIDTH-1:0] st_merged;

   lsu_align u_align (
      .funct3    (f3_q),
      .ofs       (addr_q[1:0]),
      .mem_word  (mem_q),
      .st_data   (wdata_q),
      .ld_data   (ld_data),
      .st_merged (st_merged)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      f3_d         = f3_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_we_d     = 1'b0;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               f3_d    = req_funct3;
               wdata_d = req_wdata;
               we_d    = req_we;
               if (req_err(req_funct3, req_addr[1:0])) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = '0;
                  resp_err_d   = 1'b1;
               end else begin
                  mem_addr_d = {req_addr[ADDR_WIDTH-1:WORD_OFS], {WORD_OFS{1'b0}}};
                  if (req_we && req_funct3 == F3_W) begin
                     mem_data_d = req_wdata;
                     mem_we_d   = 1'b1;
                     state_d    = S_WR;
                  end else begin
                     state_d = S_RD;
                  end
               end
            end
         end
         S_RD: state_d = S_RDW;
         S_RDW: begin
            if (we_q) begin
               mem_data_d = st_merged;
               mem_we_d   = 1'b1;
               state_d    = S_WR;
            end else begin
               resp_rdata_d = ld_data;
               resp_err_d   = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = S_RESP;
            end
         end
         S_WR: begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         f3_q         <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_we_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         f3_q         <= f3_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_we_q     <= mem_we_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl against a word RAM model with one-cycle registered read.
module tb_lsu_mem_ctrl;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_we;
   logic [31:0] mem_q;

   logic [31:0] ram [0:63];
   int          n_pass;
   int          n_total;
   int          we_cnt;
   int          rv_cnt;
   int          acc_cnt;
   logic [31:0] last_we_addr;
   logic [31:0] last_we_data;

   lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_we     (mem_we),
      .mem_q      (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: read returns the pre-write word, registered one cycle after the address.
   always @(posedge clk) begin
      mem_q <= ram[mem_addr[7:2]];
      if (mem_we) begin
         ram[mem_addr[7:2]] = mem_data;
         we_cnt++;
         last_we_addr = mem_addr;
         last_we_data = mem_data;
      end
      if (resp_valid) rv_cnt++;
      if (!reset && req_valid && req_ready) acc_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid) lat = 99;
   endtask

   task automatic step_to_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready); else n_pass++;
      n_total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else n_pass++;
      n_total++; if (resp_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", resp_rdata); else n_pass++;
      n_total++; if (resp_err !== 1'b0) $display("FAIL rst_err got %b want 0", resp_err); else n_pass++;
      n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b want 0", mem_we); else n_pass++;
      n_total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else n_pass++;
      n_total++; if (mem_data !== 32'h0) $display("FAIL rst_mem_data got %h want 0", mem_data); else n_pass++;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_word();
      int lat;
      ram[4] = 32'hDEADBEEF;
      do_req(1'b0, 3'd2, 32'h10, 32'h0, lat);
      n_total++; if (lat !== 3) $display("FAIL lw_latency got %0d want 3", lat); else n_pass++;
      n_total++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", resp_rdata); else n_pass++;
      n_total++; if (resp_err !== 1'b0) $display("FAIL lw_err got %b want 0", resp_err); else n_pass++;
      step_to_idle();
   endtask

   task automatic test_load_subword();
      int lat;
      ram[4] = 32'h80FF7F01;
      do_req(1'b0, 3'd0, 32'h13, 32'h0, lat);
      n_total++; if (resp_rdata !== 32'hFFFFFF80) $display("FAIL lb13 got %h want ffffff80", resp_rdata); else n_pass++;
      n_total++; if (lat !== 3) $display("FAIL lb_latency got %0d want 3", lat); else n_pass++;
      step_to_idle();
      do_req(1'b0, 3'd4, 32'h13, 32'h0, lat);
      n_total++; if (resp_rdata !== 32'h00000080) $display("FAIL lbu13 got %h want 00000080", resp_rdata); else n_pass++;
      step_to_idle();
      do_req(1'b0, 3'd1, 32'h12, 32'h0, lat);
      n_total++; if (resp_rdata !== 32'hFFFF80FF) $display("FAIL lh12 got %h want ffff80ff", resp_rdata); else n_pass++;
      step_to_idle();
      do_req(1'b0, 3'd5, 32'h12, 32'h0, lat);
      n_total++; if (resp_rdata !== 32'h000080FF) $display("FAIL lhu12 got %h want 000080ff", resp_rdata); else n_pass++;
      step_to_idle();
      do_req(1'b0, 3'd0, 32'h11, 32'h0, lat);
      n_total++; if (resp_rdata !== 32'h0000007F) $display("FAIL lb11 got %h want 0000007f", resp_rdata); else n_pass++;
      step_to_idle();
      do_req(1'b0, 3'd1, 32'h10, 32'h0, lat);
      n_total++; if (resp_rdata !== 32'h00007F01) $display("FAIL lh10 got %h want 00007f01", resp_rdata); else n_pass++;
      step_to_idle();
   endtask

   task automatic test_store_subword();
      int lat;
      int we0;
      ram[8] = 32'h11223344;
      we0 = we_cnt;
      do_req(1'b1, 3'd0, 32'h21, 32'h000000AA, lat);
      n_total++; if (lat !== 4) $display("FAIL sb_latency got %0d want 4", lat); else n_pass++;
      n_total++; if (we_cnt - we0 !== 1) $display("FAIL sb_we_pulses got %0d want 1", we_cnt - we0); else n_pass++;
      n_total++; if (last_we_addr !== 32'h20) $display("FAIL sb_we_addr got %h want 00000020", last_we_addr); else n_pass++;
      n_total++; if (last_we_data !== 32'h1122AA44) $display("FAIL sb_we_data got %h want 1122aa44", last_we_data); else n_pass++;
      n_total++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) $display("FAIL sb_resp got %h/%b want 0/0", resp_rdata, resp_err); else n_pass++;
      step_to_idle();
      do_req(1'b1, 3'd1, 32'h22, 32'h1234BEEF, lat);
      n_total++; if (lat !== 4) $display("FAIL sh_latency got %0d want 4", lat); else n_pass++;
      n_total++; if (ram[8] !== 32'hBEEFAA44) $display("FAIL sh_merge got %h want beefaa44", ram[8]); else n_pass++;
      step_to_idle();
   endtask

   task automatic test_errors();
      int lat;
      int we0;
      logic [31:0] addr0;
      we0   = we_cnt;
      addr0 = mem_addr;
      do_req(1'b1, 3'd1, 32'h03, 32'hFFFF, lat);
      n_total++; if (lat !== 1) $display("FAIL sh_mis_latency got %0d want 1", lat); else n_pass++;
      n_total++; if (resp_err !== 1'b1) $display("FAIL sh_mis_err got %b want 1", resp_err); else n_pass++;
      n_total++; if (mem_addr !== addr0) $display("FAIL sh_mis_addr got %h want %h", mem_addr, addr0); else n_pass++;
      step_to_idle();
      do_req(1'b0, 3'd2, 32'h06, 32'h0, lat);
      n_total++; if (lat !== 1 || resp_err !== 1'b1) $display("FAIL lw_mis got lat %0d err %b want 1/1", lat, resp_err); else n_pass++;
      n_total++; if (resp_rdata !== 32'h0) $display("FAIL lw_mis_data got %h want 0", resp_rdata); else n_pass++;
      step_to_idle();
      do_req(1'b0, 3'd3, 32'h00, 32'h0, lat);
      n_total++; if (lat !== 1 || resp_err !== 1'b1) $display("FAIL f3_illegal got lat %0d err %b want 1/1", lat, resp_err); else n_pass++;
      step_to_idle();
      n_total++; if (we_cnt !== we0) $display("FAIL err_no_write got %0d want %0d", we_cnt, we0); else n_pass++;
      n_total++; if (mem_addr !== addr0) $display("FAIL err_addr_hold got %h want %h", mem_addr, addr0); else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int lat;
      int we0;
      int rv0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd0;
      req_addr   = 32'h21;
      req_wdata  = 32'h00000055;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      we0 = we_cnt;
      rv0 = rv_cnt;
      @(posedge clk); #1;
      n_total++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", req_ready); else n_pass++;
      n_total++; if (mem_we !== 1'b0 || mem_addr !== 32'h0) $display("FAIL midrst_mem got we %b addr %h want 0/0", mem_we, mem_addr); else n_pass++;
      reset = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      n_total++; if (rv_cnt !== rv0) $display("FAIL midrst_no_resp got %0d want %0d", rv_cnt, rv0); else n_pass++;
      n_total++; if (we_cnt !== we0) $display("FAIL midrst_no_write got %0d want %0d", we_cnt, we0); else n_pass++;
      n_total++; if (ram[8] !== 32'hBEEFAA44) $display("FAIL midrst_mem_word got %h want beefaa44", ram[8]); else n_pass++;
      do_req(1'b0, 3'd2, 32'h20, 32'h0, lat);
      n_total++; if (lat !== 3 || resp_rdata !== 32'hBEEFAA44) $display("FAIL post_rst_lw got lat %0d data %h want 3/beefaa44", lat, resp_rdata); else n_pass++;
      step_to_idle();
   endtask

   task automatic test_back_to_back();
      int lat;
      int acc0;
      logic ready_bad;
      acc0       = acc_cnt;
      ready_bad  = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h40;
      req_wdata  = 32'h5A5AC3C3;
      @(posedge clk); #1;
      req_we    = 1'b0;
      req_wdata = 32'h0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         if (req_ready) ready_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      if (req_ready) ready_bad = 1'b1;
      n_total++; if (lat !== 2) $display("FAIL b2b_sw_latency got %0d want 2", lat); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (req_ready !== 1'b1) $display("FAIL b2b_idle_ready got %b want 1", req_ready); else n_pass++;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         if (req_ready) ready_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      n_total++; if (lat !== 3) $display("FAIL b2b_lw_latency got %0d want 3", lat); else n_pass++;
      n_total++; if (resp_rdata !== 32'h5A5AC3C3) $display("FAIL b2b_lw_data got %h want 5a5ac3c3", resp_rdata); else n_pass++;
      n_total++; if (ready_bad !== 1'b0) $display("FAIL b2b_ready_low got %b want 0", ready_bad); else n_pass++;
      step_to_idle();
      n_total++; if (acc_cnt - acc0 !== 2) $display("FAIL b2b_accepts got %0d want 2", acc_cnt - acc0); else n_pass++;
   endtask

   initial begin
      n_pass     = 0;
      n_total    = 0;
      we_cnt     = 0;
      rv_cnt     = 0;
      acc_cnt    = 0;
      last_we_addr = '0;
      last_we_data = '0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = '0;
      req_wdata  = '0;
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;

      test_reset();
      test_load_word();
      test_load_subword();
      test_store_subword();
      test_errors();
      test_reset_mid_op();
      test_back_to_back();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
